// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared register offsets, status bit positions and FSM state encodings
// for the memory-mapped UART.
package io_uart_pkg;

  // Register offsets relative to the block's base I/O address
  localparam logic [7:0] REG_DATA   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;

  // Status register bit positions
  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_RXVALID = 3;
  localparam int ST_OVERRUN = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/io_uart_fifo.sv
// io_uart_fifo: small synchronous FIFO with extra pointer bit so full and empty
// are distinguishable; pushes while full and pops while empty are ignored.
module io_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_dout   = r_mem[r_rdPtr[AW-1:0]];

  // Pointer update; full is judged on the pre-edge state so a same-edge pop never frees room for a push
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate every read
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with a TX FIFO and data/status registers on the
// CPU I/O bus. The receiver is only built when IO_UART_RX_EN is defined.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         CLKS_PER_BIT = 16,
  parameter int         TX_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  output logic       o_tx,
  input  logic       i_rx
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic       w_hitData;
  logic       w_hitStatus;
  logic       w_wrStrobe;
  logic       w_push;
  logic       w_fifoFull;
  logic       w_fifoEmpty;
  logic [7:0] w_fifoDout;
  logic       w_txPop;
  logic [7:0] w_status;
  logic       w_rxValid;
  logic       w_overrun;
  logic [7:0] w_rxData;
  logic       r_nweQ;

  tx_state_t        r_txState, w_txStateNext;
  logic [CNT_W-1:0] r_txCnt, w_txCntNext;
  logic [2:0]       r_txBit, w_txBitNext;
  logic [7:0]       r_txShift, w_txShiftNext;
  logic             r_tx, w_txNext;

  assign w_hitData   = i_ioSelect && (i_ioAddress == BASE_ADDR + REG_DATA);
  assign w_hitStatus = i_ioSelect && (i_ioAddress == BASE_ADDR + REG_STATUS);
  assign o_busNOE    = !((w_hitData || w_hitStatus) && !i_ioNOE);
  assign w_wrStrobe  = !i_ioNWE && r_nweQ;
  assign w_push      = w_wrStrobe && w_hitData;
  assign o_tx        = r_tx;

  // Remember the last sampled write strobe so a long strobe acts only once
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_nweQ <= 1'b1;
    else         r_nweQ <= i_ioNWE;
  end

  io_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_txPop),
    .i_din   (i_bus),
    .o_dout  (w_fifoDout),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Assemble the status register from FIFO, transmitter and receiver flags
  always_comb begin
    w_status              = 8'h00;
    w_status[ST_FULL]     = w_fifoFull;
    w_status[ST_EMPTY]    = w_fifoEmpty && (r_txState == TX_IDLE);
    w_status[ST_BUSY]     = (r_txState != TX_IDLE);
    w_status[ST_RXVALID]  = w_rxValid;
    w_status[ST_OVERRUN]  = w_overrun;
  end

  // Combinational read mux; the bus floats high whenever this block is not addressed
  always_comb begin
    o_bus = 8'hff;
    if (w_hitData && !i_ioNOE)        o_bus = w_rxValid ? w_rxData : 8'h00;
    else if (w_hitStatus && !i_ioNOE) o_bus = w_status;
  end

  // Transmitter state register; o_tx is registered so reset forces the line idle immediately
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= 3'd0;
      r_txShift <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
      r_tx      <= w_txNext;
    end
  end

  // Transmitter next-state logic; leaving STOP with data pending goes straight to START
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_txNext      = r_tx;
    w_txPop       = 1'b0;
    case (r_txState)
      TX_IDLE: begin
        w_txCntNext = '0;
        w_txNext    = 1'b1;
        if (!w_fifoEmpty) begin
          w_txPop       = 1'b1;
          w_txShiftNext = w_fifoDout;
          w_txStateNext = TX_START;
          w_txNext      = 1'b0;
        end
      end
      TX_START: begin
        if (r_txCnt == LAST_CNT) begin
          w_txCntNext   = '0;
          w_txBitNext   = 3'd0;
          w_txStateNext = TX_DATA;
          w_txNext      = r_txShift[0];
        end
      end
      TX_DATA: begin
        if (r_txCnt == LAST_CNT) begin
          w_txCntNext = '0;
          if (r_txBit == 3'd7) begin
            w_txStateNext = TX_STOP;
            w_txNext      = 1'b1;
          end else begin
            w_txBitNext   = r_txBit + 1'b1;
            w_txShiftNext = {1'b0, r_txShift[7:1]};
            w_txNext      = r_txShift[1];
          end
        end
      end
      TX_STOP: begin
        if (r_txCnt == LAST_CNT) begin
          w_txCntNext = '0;
          if (!w_fifoEmpty) begin
            w_txPop       = 1'b1;
            w_txShiftNext = w_fifoDout;
            w_txStateNext = TX_START;
            w_txNext      = 1'b0;
          end else begin
            w_txStateNext = TX_IDLE;
            w_txNext      = 1'b1;
          end
        end
      end
      default: begin
        w_txStateNext = TX_IDLE;
        w_txNext      = 1'b1;
      end
    endcase
  end

`ifdef IO_UART_RX_EN
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_rxSync;
  logic             r_rxPrev;
  logic             w_rxIn;
  rx_state_t        r_rxState, w_rxStateNext;
  logic [CNT_W-1:0] r_rxCnt, w_rxCntNext;
  logic [2:0]       r_rxBit, w_rxBitNext;
  logic [7:0]       r_rxShift, w_rxShiftNext;
  logic             w_rxDone;
  logic [7:0]       r_rxData;
  logic             r_rxValid;
  logic             r_overrun;
  logic             r_rdQ;
  logic             w_rxPop;
  logic             w_clrOvr;

  assign w_rxIn    = r_rxSync[1];
  assign w_rxPop   = r_rdQ && i_ioNOE;
  assign w_clrOvr  = w_wrStrobe && w_hitStatus && i_bus[ST_OVERRUN];
  assign w_rxValid = r_rxValid;
  assign w_overrun = r_overrun;
  assign w_rxData  = r_rxData;

  // Two-flop synchroniser for the asynchronous serial input, plus a history flop for edge detect
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rxSync <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_rxSync <= {r_rxSync[0], i_rx};
      r_rxPrev <= r_rxSync[1];
    end
  end

  // Track a data-register read so the pop lands when the read strobe is released
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rdQ <= 1'b0;
    else         r_rdQ <= w_hitData && !i_ioNOE;
  end

  // Receiver state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rxState <= RX_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= 3'd0;
      r_rxShift <= 8'h00;
    end else begin
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
    end
  end

  // Receiver next-state logic; a half-bit start check rejects glitches, then samples mid-bit
  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt + 1'b1;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxDone      = 1'b0;
    case (r_rxState)
      RX_IDLE: begin
        w_rxCntNext = '0;
        if (r_rxPrev && !w_rxIn) w_rxStateNext = RX_START;
      end
      RX_START: begin
        if (r_rxCnt == MID_CNT) begin
          w_rxCntNext   = '0;
          w_rxBitNext   = 3'd0;
          w_rxStateNext = w_rxIn ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rxCnt == LAST_CNT) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {w_rxIn, r_rxShift[7:1]};
          if (r_rxBit == 3'd7) w_rxStateNext = RX_STOP;
          else                 w_rxBitNext   = r_rxBit + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rxCnt == LAST_CNT) begin
          w_rxCntNext   = '0;
          w_rxStateNext = RX_IDLE;
          w_rxDone      = w_rxIn;
        end
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  // Holding register: a new byte loads if the old one is gone or being popped, otherwise it is lost
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rxData  <= 8'h00;
      r_rxValid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_rxDone) begin
        if (!r_rxValid || w_rxPop) begin
          r_rxData  <= r_rxShift;
          r_rxValid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_rxPop) begin
        r_rxValid <= 1'b0;
      end
      if (w_clrOvr) r_overrun <= 1'b0;
    end
  end
`else
  logic w_unusedRx;

  assign w_unusedRx = i_rx;
  assign w_rxValid  = 1'b0;
  assign w_overrun  = 1'b0;
  assign w_rxData   = 8'h00;
`endif

endmodule
